// File: rtl/gate_tt_exerciser.sv
// Truth-table exerciser for an N_IN-input combinational gate. It drives every input
// vector, waits SETTLE cycles, samples dut_y and checks it against EXPECT. Define
// TT_ERRLOG_EN to add the err_map port, which records one mismatch bit per vector.
module gate_tt_exerciser #(
    parameter int                   N_IN   = 2,
    parameter logic [2**N_IN-1:0]   EXPECT = 4'b1110,
    parameter int                   SETTLE = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [N_IN-1:0]   stim,
    input  logic              dut_y,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     fail_count,
    output logic [N_IN-1:0]   first_fail
`ifdef TT_ERRLOG_EN
    ,
    output logic [2**N_IN-1:0] err_map
`endif
);

    localparam int              NVEC     = 2**N_IN;
    localparam logic [N_IN-1:0] LAST     = N_IN'(NVEC - 1);
    localparam logic [3:0]      CNT_INIT = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] cnt;
    logic       accept;
    logic       mismatch;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        mismatch   = (dut_y != EXPECT[stim]);
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt == 4'd0) begin
                    state_next = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                state_next = (stim == LAST) ? S_DONE : S_SETTLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign busy = (state == S_SETTLE) || (state == S_SAMPLE);
    assign pass = (state == S_DONE) && (fail_count == '0);

    // Stimulus, settle counter and result registers; only the first mismatch of a sweep latches first_fail.
    always_ff @(posedge clk) begin
        if (rst) begin
            stim       <= '0;
            cnt        <= '0;
            done       <= 1'b0;
            fail_count <= '0;
            first_fail <= '0;
        end else begin
            done <= (state_next == S_DONE);
            if (accept) begin
                stim       <= '0;
                cnt        <= CNT_INIT;
                fail_count <= '0;
                first_fail <= '0;
            end else if (state == S_SETTLE) begin
                if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end
            end else if (state == S_SAMPLE) begin
                if (mismatch) begin
                    fail_count <= fail_count + 1'b1;
                    if (fail_count == '0) begin
                        first_fail <= stim;
                    end
                end
                if (stim != LAST) begin
                    stim <= stim + 1'b1;
                    cnt  <= CNT_INIT;
                end
            end
        end
    end

`ifdef TT_ERRLOG_EN
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            err_map <= '0;
        end else if (state == S_SAMPLE && mismatch) begin
            err_map[stim] <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_gate_tt_exerciser.sv
// Self-checking bench for gate_tt_exerciser: three instances (OR default, NAND table,
// 1-input inverter table) driven by behavioural gate models, results checked via a scoreboard.
module tb_gate_tt_exerciser;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start_a, start_b, start_c;
    logic [1:0] stim_a, stim_b;
    logic [0:0] stim_c;
    logic       y_a, y_b, y_c;
    logic       busy_a, busy_b, busy_c;
    logic       done_a, done_b, done_c;
    logic       pass_a, pass_b, pass_c;
    logic [2:0] fc_a, fc_b;
    logic [1:0] fc_c;
    logic [1:0] ff_a, ff_b;
    logic [0:0] ff_c;
`ifdef TT_ERRLOG_EN
    logic [3:0] em_a;
    logic [3:0] em_b;
    logic [1:0] em_c;
`endif

    int mode_a, mode_b, mode_c;
    int sel;
    int n_compared   = 0;
    int n_mismatched = 0;

    typedef struct {
        logic [2:0] fc;
        logic [1:0] ff;
        logic       pass;
        logic [3:0] em;
    } exp_t;
    exp_t sb_q[$];

    // Gate models: 0 = OR, 1 = stuck at 0, 2 = NAND; instance C: 0 = inverter, 1 = buffer.
    always_comb begin
        case (mode_a)
            0:       y_a = |stim_a;
            1:       y_a = 1'b0;
            default: y_a = ~&stim_a;
        endcase
        case (mode_b)
            0:       y_b = |stim_b;
            1:       y_b = 1'b0;
            default: y_b = ~&stim_b;
        endcase
        y_c = (mode_c == 0) ? ~stim_c[0] : stim_c[0];
    end

    gate_tt_exerciser u_or (
        .clk(clk), .rst(rst), .start(start_a), .stim(stim_a), .dut_y(y_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .fail_count(fc_a), .first_fail(ff_a)
`ifdef TT_ERRLOG_EN
        , .err_map(em_a)
`endif
    );

    gate_tt_exerciser #(.EXPECT(4'b0111)) u_nand (
        .clk(clk), .rst(rst), .start(start_b), .stim(stim_b), .dut_y(y_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .fail_count(fc_b), .first_fail(ff_b)
`ifdef TT_ERRLOG_EN
        , .err_map(em_b)
`endif
    );

    gate_tt_exerciser #(.N_IN(1), .SETTLE(1), .EXPECT(2'b01)) u_inv (
        .clk(clk), .rst(rst), .start(start_c), .stim(stim_c), .dut_y(y_c),
        .busy(busy_c), .done(done_c), .pass(pass_c), .fail_count(fc_c), .first_fail(ff_c)
`ifdef TT_ERRLOG_EN
        , .err_map(em_c)
`endif
    );

    logic [1:0] o_stim;
    logic [2:0] o_fc;
    logic [1:0] o_ff;
    logic       o_busy, o_done, o_pass;
    always_comb begin
        case (sel)
            0: begin
                o_stim = stim_a; o_fc = fc_a; o_ff = ff_a;
                o_busy = busy_a; o_done = done_a; o_pass = pass_a;
            end
            1: begin
                o_stim = stim_b; o_fc = fc_b; o_ff = ff_b;
                o_busy = busy_b; o_done = done_b; o_pass = pass_b;
            end
            default: begin
                o_stim = {1'b0, stim_c}; o_fc = {1'b0, fc_c}; o_ff = {1'b0, ff_c};
                o_busy = busy_c; o_done = done_c; o_pass = pass_c;
            end
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic drive_start(input int s, input logic v);
        case (s)
            0:       start_a = v;
            1:       start_b = v;
            default: start_c = v;
        endcase
    endtask

    task automatic applyStimulus(input int s, input int mode, input bit push,
                                 input logic [2:0] fc, input logic [1:0] ff,
                                 input logic pass, input logic [3:0] em);
        exp_t e;
        @(negedge clk);
        sel = s;
        case (s)
            0:       mode_a = mode;
            1:       mode_b = mode;
            default: mode_c = mode;
        endcase
        if (push) begin
            e.fc = fc; e.ff = ff; e.pass = pass; e.em = em;
            sb_q.push_back(e);
        end
        drive_start(s, 1'b1);
    endtask

    // Called at the negedge just before the start edge; follows the sweep and pops its result.
    task automatic wait_sweep(input int n_in, input int settle, input bit keep_start);
        int   lat  = (1 << n_in) * (settle + 1);
        int   last = (1 << n_in) - 1;
        int   k    = 0;
        bit   seen = 1'b0;
        exp_t e;
        @(negedge clk);
        if (!keep_start) drive_start(sel, 1'b0);
        checkOutput("busy_after_start", o_busy, 1);
        checkOutput("done_after_start", o_done, 0);
        while (!seen && k < lat + 8) begin
            if (k < lat) checkOutput("stim_seq", o_stim, k / (settle + 1));
            @(negedge clk);
            k++;
            if (o_done) seen = 1'b1;
        end
        checkOutput("latency", seen ? k : -1, lat);
        checkOutput("busy_in_done", o_busy, 0);
        checkOutput("stim_held", o_stim, last);
        if (sb_q.size() == 0) begin
            checkOutput("scoreboard_empty", 1, 0);
        end else begin
            e = sb_q.pop_front();
            checkOutput("fail_count", o_fc, e.fc);
            checkOutput("first_fail", o_ff, e.ff);
            checkOutput("pass", o_pass, e.pass);
`ifdef TT_ERRLOG_EN
            if (sel == 0) checkOutput("err_map", em_a, e.em);
`endif
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        mode_a = 0; mode_b = 0; mode_c = 0;
        sel = 0;
        repeat (3) @(negedge clk);
        checkOutput("rst_stim", stim_a, 0);
        checkOutput("rst_busy", busy_a, 0);
        checkOutput("rst_done", done_a, 0);
        checkOutput("rst_pass", pass_a, 0);
        checkOutput("rst_fail_count", fc_a, 0);
        checkOutput("rst_first_fail", ff_a, 0);
        checkOutput("rst_inv_done", done_c, 0);
        rst = 1'b0;

        $display("[TB] OR model against OR table");
        applyStimulus(0, 0, 1'b1, 3'd0, 2'd0, 1'b1, 4'b0000);
        wait_sweep(2, 2, 1'b0);

        $display("[TB] stuck-at-0 output against OR table");
        applyStimulus(0, 1, 1'b1, 3'd3, 2'd1, 1'b0, 4'b1110);
        wait_sweep(2, 2, 1'b0);

        $display("[TB] start held high through two sweeps");
        applyStimulus(0, 0, 1'b1, 3'd0, 2'd0, 1'b1, 4'b0000);
        sb_q.push_back('{fc: 3'd0, ff: 2'd0, pass: 1'b1, em: 4'b0000});
        wait_sweep(2, 2, 1'b1);
        wait_sweep(2, 2, 1'b0);

        $display("[TB] reset during settle of vector 2");
        applyStimulus(0, 1, 1'b0, 3'd0, 2'd0, 1'b0, 4'b0000);
        @(negedge clk);
        drive_start(0, 1'b0);
        repeat (7) @(negedge clk);
        checkOutput("pre_rst_stim", stim_a, 2);
        checkOutput("pre_rst_fail_count", fc_a, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("mid_rst_stim", stim_a, 0);
        checkOutput("mid_rst_fail_count", fc_a, 0);
        checkOutput("mid_rst_first_fail", ff_a, 0);
        checkOutput("mid_rst_done", done_a, 0);
        checkOutput("mid_rst_busy", busy_a, 0);
        applyStimulus(0, 0, 1'b1, 3'd0, 2'd0, 1'b1, 4'b0000);
        wait_sweep(2, 2, 1'b0);

        $display("[TB] NAND table");
        applyStimulus(1, 2, 1'b1, 3'd0, 2'd0, 1'b1, 4'b0000);
        wait_sweep(2, 2, 1'b0);
        applyStimulus(1, 0, 1'b1, 3'd2, 2'd0, 1'b0, 4'b0000);
        wait_sweep(2, 2, 1'b0);

        $display("[TB] single-input inverter table");
        applyStimulus(2, 0, 1'b1, 3'd0, 2'd0, 1'b1, 4'b0000);
        wait_sweep(1, 1, 1'b0);
        applyStimulus(2, 1, 1'b1, 3'd2, 2'd0, 1'b0, 4'b0000);
        wait_sweep(1, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
